// File: rtl/serial_add_nbit.sv
// Bit-serial N-bit adder: one operand bit pair per clock, LSB first, through a full-adder slice.
// Optional SERIAL_ADD_OVF_EN adds a registered signed-overflow flag output (ovf).
module serial_add_nbit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic         ovf,
`endif
    output logic         cout
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  op_a, op_b;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          s_bit, c_next;

    // Full-adder bit slice.
    always_comb begin
        s_bit  = op_a[0] ^ op_b[0] ^ carry;
        c_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    sum   <= {s_bit, sum[N-1:1]};
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= c_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout <= c_next;
`ifdef SERIAL_ADD_OVF_EN
                        // carry still holds the carry into bit N-1 on this edge
                        ovf  <= carry ^ c_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_nbit.sv
// Directed, table-driven bench for serial_add_nbit (N=8); checks ovf when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_nbit;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a, b;
    logic         busy, done, cout;
    logic [N-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_add_nbit #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one start pulse, then wait (bounded) for done; returns at the negedge where done=1.
    task automatic do_add(input logic [N-1:0] va, input logic [N-1:0] vb,
                          output int busy_cycles, output bit got_done);
        @(negedge clk);
        start = 1'b1;
        a = va;
        b = vb;
        @(negedge clk);
        start = 1'b0;
        a = ~va;
        b = ~vb;
        busy_cycles = 0;
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, " sum"}, 32'(sum), 32'(v.sum));
        check({tag, " cout"}, 32'(cout), 32'(v.cout));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
`endif
    endtask

    int bc;
    bit gd;
    bit saw_done;

    initial begin
        vecs[0] = '{a: 8'h03, b: 8'h05, sum: 8'h08, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h80, b: 8'h80, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        vecs[4] = '{a: 8'h64, b: 8'h64, sum: 8'hC8, cout: 1'b0, ovf: 1'b1};
        vecs[5] = '{a: 8'hF0, b: 8'h0F, sum: 8'hFF, cout: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'hAA, b: 8'h55, sum: 8'hFF, cout: 1'b0, ovf: 1'b0};
        vecs[7] = '{a: 8'hC3, b: 8'hE7, sum: 8'hAA, cout: 1'b1, ovf: 1'b0};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("reset ovf", 32'(ovf), 32'd0);
`endif

        for (int i = 0; i < 8; i++) begin
            do_add(vecs[i].a, vecs[i].b, bc, gd);
            check($sformatf("vec%0d done", i), 32'(gd), 32'd1);
            check($sformatf("vec%0d busy_cycles", i), 32'(bc), 32'(N));
            check($sformatf("vec%0d busy_at_done", i), 32'(busy), 32'd0);
            check_result($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d done_pulse", i), 32'(done), 32'd0);
            @(negedge clk);
            check_result($sformatf("vec%0d hold", i), vecs[i]);
        end

        // Start during RUN must be ignored.
        @(negedge clk);
        start = 1'b1;
        a = 8'h10;
        b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        gd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                gd = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ignore done", 32'(gd), 32'd1);
        check("ignore sum", 32'(sum), 32'h30);
        check("ignore cout", 32'(cout), 32'd0);

        // Back-to-back: start in the IDLE cycle right after done.
        do_add(8'h01, 8'h01, bc, gd);
        check("b2b done", 32'(gd), 32'd1);
        check("b2b busy_cycles", 32'(bc), 32'(N));
        check("b2b sum", 32'(sum), 32'h02);
        check("b2b cout", 32'(cout), 32'd0);

        // Reset asserted in the 3rd RUN cycle aborts the operation.
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort no_done", 32'(saw_done), 32'd0);

        do_add(8'hAA, 8'h55, bc, gd);
        check("after_abort done", 32'(gd), 32'd1);
        check("after_abort sum", 32'(sum), 32'hFF);
        check("after_abort cout", 32'(cout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
